prog_clock_divider: RTL and testbench

//   Multi-channel, runtime-programmable clock divider. Generates CHANNELS independent divided

---
 rtl/prog_clock_divider.sv | 85 ++++++++
 tb/tb_prog_clock_divider.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_clock_divider.sv
// rtl/prog_clock_divider.sv - multi-channel programmable clock divider with sync and divisor shadowing
module prog_clock_divider #(
    parameter int CHANNELS    = 2,
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 10,
    localparam int SEL_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] enable,
    input  logic                sync,
    input  logic                div_wr,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] out_clk,
    output logic [CHANNELS-1:0] tick
);

    localparam int               DEF_CLAMP = (DEFAULT_DIV < 2) ? 2 : DEFAULT_DIV;
    localparam logic [WIDTH-1:0] DEF_DIV   = DEF_CLAMP[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    logic [WIDTH-1:0]    shadow_q [CHANNELS];
    logic [WIDTH-1:0]    shadow_d [CHANNELS];
    logic [WIDTH-1:0]    div_q    [CHANNELS];
    logic [WIDTH-1:0]    div_d    [CHANNELS];
    logic [WIDTH-1:0]    cnt_q    [CHANNELS];
    logic [WIDTH-1:0]    cnt_d    [CHANNELS];
    logic [CHANNELS-1:0] out_clk_q, out_clk_d;
    logic [CHANNELS-1:0] tick_q, tick_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i]  = shadow_q[i];
            div_d[i]     = div_q[i];
            cnt_d[i]     = cnt_q[i];
            out_clk_d[i] = out_clk_q[i];
            tick_d[i]    = 1'b0;
            // The active divisor only changes at a period boundary, so no runt pulses.
            if (sync) begin
                cnt_d[i]     = '0;
                div_d[i]     = shadow_q[i];
                out_clk_d[i] = 1'b1;
            end else if (enable[i]) begin
                if (cnt_q[i] == div_q[i] - ONE) begin
                    cnt_d[i]     = '0;
                    div_d[i]     = shadow_q[i];
                    out_clk_d[i] = 1'b1;
                    tick_d[i]    = 1'b1;
                end else begin
                    cnt_d[i]     = cnt_q[i] + ONE;
                    out_clk_d[i] = (cnt_q[i] + ONE) < (div_q[i] - (div_q[i] >> 1));
                end
            end
            if (div_wr && (int'(div_sel) == i)) begin
                shadow_d[i] = (div_data < MIN_DIV) ? MIN_DIV : div_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= DEF_DIV;
                div_q[i]    <= DEF_DIV;
                cnt_q[i]    <= '0;
            end
            out_clk_q <= '1;
            tick_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                div_q[i]    <= div_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            out_clk_q <= out_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign out_clk = out_clk_q;
    assign tick    = tick_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// tb/tb_prog_clock_divider.sv - scoreboard bench for prog_clock_divider
module tb_prog_clock_divider;

    localparam int CH  = 3;
    localparam int W   = 16;
    localparam int DEF = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [CH-1:0] enable = '0;
    logic          sync = 1'b0;
    logic          div_wr = 1'b0;
    logic [1:0]    div_sel = '0;
    logic [W-1:0]  div_data = '0;
    logic [CH-1:0] out_clk;
    logic [CH-1:0] tick;

    int checks = 0;
    int failures = 0;

    int m_s[CH];
    int m_n[CH];
    int m_cnt[CH];
    bit m_out[CH];
    bit m_tick[CH];
    logic [2*CH-1:0] sb[$];
    logic [2*CH-1:0] exp_v;
    int g;

    prog_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(DEF)) dut (
        .clk(clk), .reset(reset), .enable(enable), .sync(sync), .div_wr(div_wr),
        .div_sel(div_sel), .div_data(div_data), .out_clk(out_clk), .tick(tick)
    );

    always #5 clk = ~clk;

    // Drives one cycle, advances the reference model and queues the expected outputs.
    task automatic drive(input bit rst, input logic [CH-1:0] en, input bit sy,
                         input bit wr, input int sel, input int data);
        logic [2*CH-1:0] e;
        reset = rst; enable = en; sync = sy; div_wr = wr;
        div_sel = sel[1:0]; div_data = data[W-1:0];
        for (int c = 0; c < CH; c++) begin
            if (rst) begin
                m_s[c] = DEF; m_n[c] = DEF; m_cnt[c] = 0; m_out[c] = 1; m_tick[c] = 0;
            end else if (sy) begin
                m_cnt[c] = 0; m_n[c] = m_s[c]; m_out[c] = 1; m_tick[c] = 0;
            end else if (en[c]) begin
                if (m_cnt[c] == m_n[c] - 1) begin
                    m_cnt[c] = 0; m_n[c] = m_s[c]; m_out[c] = 1; m_tick[c] = 1;
                end else begin
                    m_cnt[c]++;
                    m_out[c] = (m_cnt[c] < (m_n[c] + 1) / 2);
                    m_tick[c] = 0;
                end
            end else begin
                m_tick[c] = 0;
            end
        end
        if (!rst && wr && sel < CH) m_s[sel] = (data < 2) ? 2 : data;
        for (int c = 0; c < CH; c++) begin
            e[CH + c] = m_out[c];
            e[c]      = m_tick[c];
        end
        sb.push_back(e);
        g = rst ? 0 : g + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, '1, 0, 0, 0, 0);
        exp_v = sb.pop_front();
        checks++;
        if ({out_clk, tick} !== exp_v) begin
            failures++;
            $display("FAIL reset_sb got=%b exp=%b", {out_clk, tick}, exp_v);
        end
        checks++;
        if (out_clk !== 3'b111 || tick !== 3'b000) begin
            failures++;
            $display("FAIL reset_state out_clk=%b tick=%b exp out_clk=111 tick=000", out_clk, tick);
        end
    endtask

    task automatic test_default_div();
        for (int k = 1; k <= 30; k++) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v) begin
                failures++;
                $display("FAIL default_sb k=%0d got=%b exp=%b", k, {out_clk, tick}, exp_v);
            end
            checks++;
            if (tick[0] !== (k % 10 == 0) || out_clk[0] !== ((k % 10) < 5)) begin
                failures++;
                $display("FAIL default_ch0 k=%0d out=%b tick=%b exp out=%0d tick=%0d",
                         k, out_clk[0], tick[0], (k % 10) < 5, k % 10 == 0);
            end
        end
    endtask

    task automatic test_write_mid();
        for (int k = 0; k < 30; k++) begin
            drive(0, '1, 0, (k == 4), 1, 3);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v) begin
                failures++;
                $display("FAIL write_mid_sb k=%0d got=%b exp=%b", k, {out_clk, tick}, exp_v);
            end
            checks++;
            if (tick[0] !== (g % 10 == 0)) begin
                failures++;
                $display("FAIL write_mid_ch0 g=%0d tick0=%b exp=%0d", g, tick[0], g % 10 == 0);
            end
        end
    endtask

    task automatic test_small_div();
        int vals[3] = '{0, 1, 5};
        int sels[3] = '{2, 2, 3};
        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 14; k++) begin
                drive(0, '1, 0, (k == 0), sels[t], vals[t]);
                exp_v = sb.pop_front();
                checks++;
                if ({out_clk, tick} !== exp_v) begin
                    failures++;
                    $display("FAIL small_div_sb t=%0d k=%0d got=%b exp=%b", t, k, {out_clk, tick}, exp_v);
                end
            end
        end
        // Once N=2 is in effect channel 2 toggles every cycle.
        for (int k = 0; k < 4; k++) begin
            logic prev;
            prev = out_clk[2];
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if (out_clk[2] !== ~prev || tick[2] !== ~prev) begin
                failures++;
                $display("FAIL small_div_toggle k=%0d out2=%b tick2=%b prev=%b", k, out_clk[2], tick[2], prev);
            end
        end
    endtask

    task automatic test_freeze();
        int budget = 0;
        logic held;
        while (m_cnt[0] != 3 && budget < 20) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            budget++;
        end
        checks++;
        if (m_cnt[0] != 3) begin
            failures++;
            $display("FAIL freeze_reach cnt=%0d exp=3", m_cnt[0]);
        end
        held = out_clk[0];
        for (int k = 0; k < 7; k++) begin
            drive(0, 3'b110, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v || out_clk[0] !== held || tick[0] !== 1'b0) begin
                failures++;
                $display("FAIL freeze_hold k=%0d got=%b exp=%b held=%b", k, {out_clk, tick}, exp_v, held);
            end
        end
        for (int k = 1; k <= 12; k++) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v || tick[0] !== (k == 7)) begin
                failures++;
                $display("FAIL freeze_resume k=%0d got=%b exp=%b tick0_exp=%0d", k, {out_clk, tick}, exp_v, k == 7);
            end
        end
    endtask

    task automatic test_sync();
        drive(0, '1, 0, 1, 0, 4);
        void'(sb.pop_front());
        drive(0, '1, 0, 1, 1, 6);
        void'(sb.pop_front());
        for (int k = 0; k < 17; k++) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v) begin
                failures++;
                $display("FAIL sync_pre_sb k=%0d got=%b exp=%b", k, {out_clk, tick}, exp_v);
            end
        end
        drive(0, '1, 1, 0, 0, 0);
        exp_v = sb.pop_front();
        checks++;
        if (out_clk !== 3'b111 || tick !== 3'b000 || {out_clk, tick} !== exp_v) begin
            failures++;
            $display("FAIL sync_align out_clk=%b tick=%b exp out_clk=111 tick=000", out_clk, tick);
        end
        for (int k = 1; k <= 12; k++) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v || (tick[0] & tick[1]) !== (k == 12)) begin
                failures++;
                $display("FAIL sync_common k=%0d got=%b exp=%b common_exp=%0d", k, {out_clk, tick}, exp_v, k == 12);
            end
        end
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        while (m_out[1] != 0 && budget < 20) begin
            drive(0, '1, 0, 0, 0, 0);
            void'(sb.pop_front());
            budget++;
        end
        checks++;
        if (out_clk[1] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_low out1=%b exp=0", out_clk[1]);
        end
        drive(1, '1, 0, 1, 1, 3);
        exp_v = sb.pop_front();
        checks++;
        if (out_clk !== 3'b111 || tick !== 3'b000 || {out_clk, tick} !== exp_v) begin
            failures++;
            $display("FAIL reset_mid_state out_clk=%b tick=%b exp out_clk=111 tick=000", out_clk, tick);
        end
        for (int k = 1; k <= 20; k++) begin
            drive(0, '1, 0, 0, 0, 0);
            exp_v = sb.pop_front();
            checks++;
            if ({out_clk, tick} !== exp_v || tick !== ((k % 10 == 0) ? 3'b111 : 3'b000)) begin
                failures++;
                $display("FAIL reset_mid_run k=%0d got=%b exp=%b", k, {out_clk, tick}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_default_div();
        test_write_mid();
        test_small_div();
        test_freeze();
        test_sync();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
